// File: rtl/alu_pkg.sv
// Shared ALU types plus the arbiter's state encoding and request-count limit.
package alu_pkg;

  typedef logic [7:0]  operand_t;
  typedef logic [15:0] result_t;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ADD = 3'd1,
    SUB = 3'd2,
    NOT = 3'd3,
    XOR = 3'd4,
    AND = 3'd5,
    MUL = 3'd6,
    INC = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_MAX_REQ = 8;

  // One latched operation as presented to the ALU.
  typedef struct packed {
    opcode_t  op;
    operand_t a;
    operand_t b;
  } alu_op_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side signals of the shared-ALU arbiter.
interface alu_arbiter_if #(parameter int NUM_REQ = 4);
  import alu_pkg::*;

  logic     [NUM_REQ-1:0] req_valid;
  operand_t [NUM_REQ-1:0] req_a;
  operand_t [NUM_REQ-1:0] req_b;
  opcode_t  [NUM_REQ-1:0] req_op;
  logic     [NUM_REQ-1:0] req_ready;
  logic     [NUM_REQ-1:0] rsp_valid;
  result_t                rsp_result;
  logic                   rsp_err;
  operand_t               alu_a;
  operand_t               alu_b;
  opcode_t                alu_opcode;
  logic                   alu_start;
  result_t                alu_result;
  logic                   alu_done;
  logic                   busy;
  logic     [7:0]         timeout_cnt;

  modport master (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_done,
    output req_ready, rsp_valid, rsp_result, rsp_err,
           alu_a, alu_b, alu_opcode, alu_start, busy, timeout_cnt
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, alu_result, alu_done,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           alu_a, alu_b, alu_opcode, alu_start, busy, timeout_cnt
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one tinyalu between NUM_REQ requesters: round-robin grant, hold start
// until done (or watchdog expiry), then a one-hot response pulse.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            reset_n,
  alu_arbiter_if.master  bus
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t           state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win;
  logic [7:0]           wd;
  alu_op_t              op_q;

  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gidx;
  logic                 gany;
  logic [IW-1:0]        ptr_nxt;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign ptr_nxt = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

  // Accept is combinational so the requester sees it in the grant cycle;
  // gating with reset keeps every output low while reset is held.
  assign bus.req_ready  = (state == IDLE && reset_n) ? gnt : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.alu_a      = op_q.a;
  assign bus.alu_b      = op_q.b;
  assign bus.alu_opcode = op_q.op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      win             <= '0;
      wd              <= '0;
      op_q            <= '0;
      bus.alu_start   <= 1'b0;
      bus.rsp_valid   <= '0;
      bus.rsp_result  <= '0;
      bus.rsp_err     <= 1'b0;
      bus.timeout_cnt <= '0;
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (gany) begin
            op_q          <= '{op: bus.req_op[gidx], a: bus.req_a[gidx], b: bus.req_b[gidx]};
            win           <= gidx;
            ptr           <= ptr_nxt;
            wd            <= '0;
            bus.alu_start <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          wd <= wd + 8'd1;
          // done has priority over an expiring watchdog in the same cycle
          if (bus.alu_done) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_err    <= 1'b0;
            bus.rsp_valid  <= NUM_REQ'(1) << win;
            bus.alu_start  <= 1'b0;
            state          <= RELEASE;
          end else if (wd == 8'(TIMEOUT - 1)) begin
            bus.rsp_result  <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_valid   <= NUM_REQ'(1) << win;
            bus.timeout_cnt <= sat_inc8(bus.timeout_cnt);
            bus.alu_start   <= 1'b0;
            state           <= RELEASE;
          end
        end
        RELEASE: begin
          wd    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one tinyalu instance between NUM_REQ requesters.
- Accepts one operation per transaction through a valid/ready handshake and drives the ALU start/opcode/operand interface.
- Holds start until the ALU reports done, then returns the result to the winning requester as a one-hot response pulse.
- Sits between the requesting blocks and tinyalu; includes a watchdog so a hung ALU cannot deadlock the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 15, maximum ALU cycles in ISSUE before the operation is aborted (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_a  input  NUM_REQ x operand_t  operand A, one per requester.
- req_b  input  NUM_REQ x operand_t  operand B, one per requester.
- req_op  input  NUM_REQ x opcode_t  opcode, one per requester.
- req_ready  output  NUM_REQ  one-hot accept pulse.
- rsp_valid  output  NUM_REQ  one-hot response pulse.
- rsp_result  output  result_t  result, valid while any rsp_valid bit is high.
- rsp_err  output  1  qualifies rsp_valid: operation timed out.
- alu_a  output  operand_t  to ALU A.
- alu_b  output  operand_t  to ALU B.
- alu_opcode  output  opcode_t  to ALU opcode.
- alu_start  output  1  to ALU start.
- alu_result  input  result_t  from ALU result.
- alu_done  input  1  from ALU done.
- busy  output  1  high in any state other than IDLE.
- timeout_cnt  output  8  saturating count of aborted operations.

Behaviour:
- Reset values: every output 0; state IDLE; round-robin pointer 0; internal watchdog counter 0.
- FSM states: IDLE, ISSUE, RELEASE.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - In that same cycle, pulse req_ready for the winner only.
  - Latch the winner's a/b/op into alu_a/alu_b/alu_opcode, and latch the winner index.
  - Set the pointer to winner+1 (wrapping), then go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - alu_start=1; alu_a/alu_b/alu_opcode held stable.
  - The watchdog increments every cycle in ISSUE.
  - If alu_done=1 is sampled: rsp_result<=alu_result, rsp_err<=0, pulse rsp_valid[winner] for exactly one cycle, go to RELEASE.
  - Else if the watchdog reaches TIMEOUT: rsp_result<=0, rsp_err<=1, pulse rsp_valid[winner], increment timeout_cnt (saturate at 255), go to RELEASE.
  - If alu_done and the timeout condition occur in the same cycle, done wins and no error is reported.
- RELEASE:
  - alu_start=0 for exactly one cycle so the ALU drops done; watchdog cleared; go to IDLE.
  - alu_done is ignored in this state.
- Latency:
  - Single-cycle ALU ops: request accept to rsp_valid = 3 cycles.
  - MUL/INC: the ALU's extra two cycles are added.
  - Minimum issue interval: 3 cycles per operation (IDLE, ISSUE, RELEASE).
- Response behaviour:
  - rsp_result and rsp_err hold their value until the next response.
  - NOP is forwarded to the ALU like any other opcode; it completes on done, and its result is whatever alu_result shows.
- Handshake rules:
  - The requester must keep req_valid/a/b/op stable until req_ready.
  - Dropping req_valid before grant withdraws the request without error.
  - A requester may re-request in the cycle after its rsp_valid.
  - With all requesters active, each is served once every NUM_REQ grants.
- Reset mid-operation:
  - Immediately forces IDLE and alu_start=0.
  - No rsp_valid is generated for the in-flight operation.
  - Pointer returns to 0.

Decomposition:
- alu_pkg:
  - Keeps existing operand_t (8b), result_t (16b) and opcode_t (NOP, ADD, SUB, NOT, XOR, AND, MUL, INC).
  - Adds arb_state_t (IDLE, ISSUE, RELEASE).
  - Adds ARB_MAX_REQ=8.
- Sub-module: rr_arbiter, a parameterised combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Instantiated once.

Test Plan:
- Single ADD: req_valid[0], A=8'h12, B=8'h34, ALU model done next cycle -> req_ready[0] one pulse; rsp_valid[0] three cycles after accept with rsp_result=16'h0046, rsp_err=0.
- MUL latency: req_valid[2], A=8'hFF, B=8'hFF -> alu_start held through the ALU's 3-cycle latency; rsp_result=16'hFE01 on rsp_valid[2]; start low exactly one cycle after.
- Round-robin fairness: all four req_valid held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; no requester served twice consecutively.
- Timeout: ALU stub never asserts done, TIMEOUT=15 -> rsp_valid[1] with rsp_err=1 and rsp_result=0 after 15 ISSUE cycles; timeout_cnt=1; next request is still served.
- Reset mid-operation: assert reset_n=0 asynchronously during ISSUE of a MUL -> alu_start, busy and all outputs 0 without waiting for a clock edge; after release, req_valid[3] alone is granted normally.
- Withdrawn request and wrap: pointer=3, req_valid[1] only -> grant 1 and pointer becomes 2; req_valid[0] pulsed and dropped while busy -> never granted, no rsp_valid[0].
